bram_stream_rd: RTL and testbench
=================================

# bram_stream_rd

Streaming reader for the single-clock iCE40 block RAM read port. On a start command it reads a contiguous, wrapping address range from memory and emits the words as a valid/ready stream with full backpressure. It absorbs the memory's one-cycle registered read latency with a small FIFO, so it sustains one word per cycle when the sink is always ready. It sits between a bram read port and any stream consumer, such as a UART transmitter or a display engine.

## Interface
- DATA_SZ, 16, bits per memory word
- ADDR_SZ, 8, bits per address; range length is up to 2^ADDR_SZ words

Ports:
- i_clk  in  1  single clock; the memory read port is clocked by the same clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start request; accepted only when o_busy=0
- i_base  in  ADDR_SZ  first address, sampled with an accepted start
- i_len  in  ADDR_SZ+1  word count 0..2^ADDR_SZ, sampled with an accepted start
- o_busy  out  1  a transfer is in progress
- o_raddr  out  ADDR_SZ  registered read address to the memory
- i_rdata  in  DATA_SZ  memory read data, valid one cycle after o_raddr is sampled
- o_valid  out  1  stream word available
- i_ready  in  1  sink accepts the word
- o_data  out  DATA_SZ  stream word
- o_last  out  1  marks the final word of the range
- o_done  out  1  one-cycle pulse when the transfer completes

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, FIFO emptying).
- IDLE -> RUN on i_start with i_len>0: capture base and length; o_raddr<=i_base; o_busy<=1.
- IDLE with i_start and i_len=0: o_busy=1 for one cycle, then o_done pulses and the block returns to IDLE. No reads are issued and o_valid never rises.
- i_start while o_busy=1 is ignored.
- Read issue:
  - One address per cycle while remaining>0 and fifo_count + inflight < 4.
  - inflight = registered address-stage valid + data-stage valid.
  - The issue decision uses registered state only; there is no combinational path from i_ready.
- Addresses increment modulo 2^ADDR_SZ (0xFF -> 0x00 for ADDR_SZ=8).
- Data-stage valid pushes i_rdata into the FIFO. The tag marking the final word is carried alongside the data to drive o_last.
- RUN -> DRAIN when the last address is issued.
- DRAIN -> IDLE on the handshake (o_valid && i_ready) of the o_last word. On that edge o_busy<=0, and o_done=1 for exactly the next cycle.
- Reset at any time: state IDLE, FIFO flushed, pipeline valids cleared. In-flight memory data is discarded.

## Timing
- Reset values: o_busy=0, o_raddr=0, o_valid=0, o_data=0, o_last=0, o_done=0.
- Stream handshake:
  - A transfer occurs on an edge with o_valid && i_ready.
  - While o_valid=1 and i_ready=0, o_data and o_last hold stable.
  - o_valid never drops without a handshake, except on reset.
- Latency: the first o_valid appears 2 edges after the edge that accepts i_start (address at E0, memory registers at E1, FIFO push at E2).
- Throughput: with i_ready held high, words leave on consecutive cycles.
- Backpressure: occupancy plus in-flight reads never exceeds 4. No word is lost or duplicated.
- Simultaneous push and pop on a full FIFO cannot occur, because the credit rule prevents it.
- o_done and a new accepted i_start are mutually exclusive, since o_busy=0 is required for acceptance.

## Structure
- Shared package: state encoding (IDLE/RUN/DRAIN) and FIFO depth constant (4, a power of two).
- Sub-module: rd_fifo.
  - 4-entry flop FIFO of {last, data}, with push/pop/count.
  - Entries reset to 0.
  - Head drives o_data/o_last; the not-empty flag drives o_valid.
- Top level holds the FSM, address counter, remaining counter (ADDR_SZ+1 bits) and the two pipeline valid bits.

## Test plan
- Reset: assert i_rst mid-cycle -> every output reads 0 immediately.
- Preload mem[a]=a*0x0101; start base=0x10, len=3, i_ready=1 -> o_data 0x1010, 0x1111, 0x1212 on consecutive cycles, first word 2 edges after start, o_last on 0x1212, o_done one cycle later.
- Wrap: base=0xFE, len=4 -> o_raddr FE, FF, 00, 01; data 0xFEFE, 0xFFFF, 0x0000, 0x0101.
- Backpressure: len=16, drop i_ready for 5 cycles after word 3 -> o_raddr stalls once occupancy plus in-flight reads reaches 4; all 16 words arrive in order with no duplicates.
- len=0 -> o_valid stays 0, o_done pulses 1 cycle after start; i_start pulsed while busy during a len=8 run -> ignored, exactly 8 words emitted.
- Reset asserted mid-stream after word 2 of 8 -> o_valid=0 and o_busy=0 at once; a following start base=0, len=2 emits a clean 2-word stream.

Source files
------------

// File: rtl/bram_stream_rd_pkg.sv
// Shared definitions for the block RAM streaming reader: controller state
// encoding, read-FIFO geometry and the credit arithmetic helper.
package bram_stream_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // FIFO depth must stay a power of two so the pointers wrap for free.
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

    // Words the reader has committed to: buffered words plus reads in the
    // address and data stages of the memory pipeline.
    function automatic logic [FIFO_CNT_W:0] occupancy(
        input logic [FIFO_CNT_W-1:0] fifo_cnt,
        input logic                  addr_vld,
        input logic                  data_vld
    );
        return {1'b0, fifo_cnt}
             + {{FIFO_CNT_W{1'b0}}, addr_vld}
             + {{FIFO_CNT_W{1'b0}}, data_vld};
    endfunction

endpackage

// File: rtl/bram_stream_rd_rd_fifo.sv
// Small flop FIFO holding {last, data} words returned by the memory. The head
// entry is presented combinationally so the stream output has no extra latency.
module bram_stream_rd_rd_fifo
    import bram_stream_rd_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [FIFO_CNT_W-1:0] count_o,
    output logic                  valid_o
);

    logic [WIDTH-1:0]      entry_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Pop only when something is held; push is refused when full as a
    // safety net, although the reader's credit rule never lets that happen.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && (count_q != FIFO_CNT_W'(FIFO_DEPTH));

    // Pointer and occupancy bookkeeping for the next cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + FIFO_CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - FIFO_CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage entries; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (push_ok) begin
            entry_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = entry_q[rd_ptr_q];
    assign count_o = count_q;
    assign valid_o = (count_q != '0);

endmodule

// File: rtl/bram_stream_rd.sv
// Streaming reader for a single-clock block RAM read port. A start command
// reads a wrapping address range and emits it as a valid/ready stream; a small
// FIFO absorbs the one-cycle registered read latency so the stream can run at
// one word per cycle, and a credit count keeps the FIFO from overflowing.
module bram_stream_rd
    import bram_stream_rd_pkg::*;
#(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ADDR_SZ-1:0] i_base,
    input  logic [ADDR_SZ:0]   i_len,
    output logic               o_busy,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_SZ-1:0] o_data,
    output logic               o_last,
    output logic               o_done
);

    state_t                state_q, state_d;
    logic [ADDR_SZ-1:0]    raddr_q, raddr_d;
    logic [ADDR_SZ:0]      remain_q, remain_d;
    logic                  addr_vld_q, addr_vld_d;
    logic                  addr_last_q, addr_last_d;
    logic                  data_vld_q;
    logic                  data_last_q;
    logic                  done_q, done_d;

    logic                  start_acc;
    logic                  issue;
    logic                  credit_ok;
    logic                  pipe_empty;
    logic                  pop;
    logic                  last_hs;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_valid;
    logic [DATA_SZ:0]      fifo_head;

    // Credit is computed from registered state only, so the sink's ready has
    // no combinational path into the read-issue logic.
    assign credit_ok  = occupancy(fifo_count, addr_vld_q, data_vld_q)
                        < (FIFO_CNT_W+1)'(FIFO_DEPTH);
    assign pipe_empty = !fifo_valid && !addr_vld_q && !data_vld_q;
    assign pop        = fifo_valid && i_ready;
    assign last_hs    = pop && fifo_head[DATA_SZ];

    // Controller state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next-state logic. A zero-length request goes straight to
    // DRAIN with nothing pending, which finishes it on the following edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = (i_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if ((remain_q == '0) ||
                    (credit_ok && (remain_q == (ADDR_SZ+1)'(1)))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_hs || pipe_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller outputs: start acceptance, read issue and completion pulse.
    always_comb begin
        start_acc = (state_q == ST_IDLE) && i_start;
        issue     = (state_q == ST_RUN) && (remain_q != '0) && credit_ok;
        done_d    = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        o_busy    = (state_q != ST_IDLE);
    end

    // Address counter and remaining-word count; the final address is tagged
    // so the tag can travel with its data through the memory pipeline.
    always_comb begin
        raddr_d     = raddr_q;
        remain_d    = remain_q;
        addr_vld_d  = 1'b0;
        addr_last_d = 1'b0;
        if (start_acc) begin
            if (i_len != '0) begin
                raddr_d     = i_base;
                addr_vld_d  = 1'b1;
                addr_last_d = (i_len == (ADDR_SZ+1)'(1));
                remain_d    = i_len - (ADDR_SZ+1)'(1);
            end else begin
                remain_d    = '0;
            end
        end else if (issue) begin
            raddr_d     = raddr_q + ADDR_SZ'(1);
            addr_vld_d  = 1'b1;
            addr_last_d = (remain_q == (ADDR_SZ+1)'(1));
            remain_d    = remain_q - (ADDR_SZ+1)'(1);
        end
    end

    // Address stage, data stage and completion registers. Clearing the
    // stage valids on reset discards whatever the memory is returning.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            raddr_q     <= '0;
            remain_q    <= '0;
            addr_vld_q  <= 1'b0;
            addr_last_q <= 1'b0;
            data_vld_q  <= 1'b0;
            data_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            raddr_q     <= raddr_d;
            remain_q    <= remain_d;
            addr_vld_q  <= addr_vld_d;
            addr_last_q <= addr_last_d;
            data_vld_q  <= addr_vld_q;
            data_last_q <= addr_last_q;
            done_q      <= done_d;
        end
    end

    bram_stream_rd_rd_fifo #(
        .WIDTH (DATA_SZ + 1)
    ) u_rd_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (data_vld_q),
        .pop_i   (pop),
        .wdata_i ({data_last_q, i_rdata}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .valid_o (fifo_valid)
    );

    assign o_raddr = raddr_q;
    assign o_valid = fifo_valid;
    assign o_data  = fifo_head[DATA_SZ-1:0];
    assign o_last  = fifo_head[DATA_SZ];
    assign o_done  = done_q;

endmodule

// File: tb/tb_bram_stream_rd.sv
// Self-checking bench for bram_stream_rd: a behavioural memory plus a
// per-transfer queue of expected words built from the range arithmetic.
module tb_bram_stream_rd;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [7:0]  i_base;
    logic [8:0]  i_len;
    logic        o_busy;
    logic [7:0]  o_raddr;
    logic [15:0] i_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_data;
    logic        o_last;
    logic        o_done;

    logic [15:0] mem [256];
    int          n_checks = 0;
    int          n_fails  = 0;

    bram_stream_rd #(
        .DATA_SZ (16),
        .ADDR_SZ (8)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_base  (i_base),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .o_raddr (o_raddr),
        .i_rdata (i_rdata),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears one edge later.
    always @(posedge clk) i_rdata <= mem[o_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transfer. mode 0: sink always ready; 1: ready dropped for 5 cycles
    // after the third word; 2: random ready. inject pulses a start while busy.
    // abort_at>0 returns as soon as that many words have been accepted.
    task automatic run_transfer(input int base, input int len, input int mode,
                                input bit inject, input int abort_at);
        logic [16:0] exp_q [$];
        logic [16:0] e;
        logic [7:0]  prev_raddr;
        logic [15:0] hold_data;
        logic        hold_last;
        bit          holding;
        int          issued, accepted, cyc, first_valid, last_hs, max_out, stall_left;

        for (int k = 0; k < len; k++) begin
            e = {(k == len - 1), mem[(base + k) % 256]};
            exp_q.push_back(e);
        end

        i_base  = 8'(base);
        i_len   = 9'(len);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);

        if (len == 0) begin
            check("zero_valid", 32'(o_valid), 32'd0);
            check("zero_done_early", 32'(o_done), 32'd0);
            @(posedge clk); #1;
            check("zero_done", 32'(o_done), 32'd1);
            check("zero_busy_clear", 32'(o_busy), 32'd0);
            check("zero_valid_late", 32'(o_valid), 32'd0);
            @(posedge clk); #1;
            check("zero_done_width", 32'(o_done), 32'd0);
            $display("transfer base=0x%02h len=0 mode=%0d words=0", base[7:0], mode);
            return;
        end

        check("raddr_first", 32'(o_raddr), 32'(base % 256));
        issued      = 1;
        accepted    = 0;
        cyc         = 0;
        first_valid = -1;
        last_hs     = -1;
        max_out     = 1;
        stall_left  = 5;
        prev_raddr  = o_raddr;
        holding     = 1'b0;
        hold_data   = '0;
        hold_last   = 1'b0;

        while (accepted < len && cyc < len * 8 + 64) begin
            if (o_raddr !== prev_raddr) begin
                issued++;
                check("raddr_seq", 32'(o_raddr), 32'((base + issued - 1) % 256));
                prev_raddr = o_raddr;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            check("issue_bound", 32'(issued <= len), 32'd1);
            check("credit", 32'((issued - accepted) <= 4), 32'd1);
            check("done_quiet", 32'(o_done), 32'd0);
            if (holding) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_data", 32'(o_data), 32'(hold_data));
                check("hold_last", 32'(o_last), 32'(hold_last));
            end
            if (o_valid === 1'b1 && first_valid < 0) first_valid = cyc;

            case (mode)
                0: i_ready = 1'b1;
                1: begin
                    if (accepted == 3 && stall_left > 0) begin
                        i_ready = 1'b0;
                        stall_left--;
                    end else begin
                        i_ready = 1'b1;
                    end
                end
                default: i_ready = ($urandom_range(3) != 0);
            endcase
            if (inject && cyc == 3) begin
                i_start = 1'b1;
                i_base  = 8'h99;
                i_len   = 9'd5;
            end

            if (o_valid === 1'b1 && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(o_data), 32'(e[15:0]));
                    check("last", 32'(o_last), 32'(e[16]));
                end
                accepted++;
                last_hs = cyc;
                holding = 1'b0;
            end else begin
                holding   = (o_valid === 1'b1);
                hold_data = o_data;
                hold_last = o_last;
            end

            @(posedge clk); #1;
            i_start = 1'b0;
            cyc++;
            if (abort_at > 0 && accepted == abort_at) return;
        end

        check("timeout_words", 32'(accepted), 32'(len));
        check("done_pulse", 32'(o_done), 32'd1);
        check("busy_clear", 32'(o_busy), 32'd0);
        check("valid_clear", 32'(o_valid), 32'd0);
        check("first_latency", 32'(first_valid), 32'd2);
        if (mode == 0) check("throughput", 32'(last_hs), 32'(len + 1));
        if (mode == 1) check("stall_fill", 32'(max_out), 32'd4);
        i_ready = 1'b0;
        @(posedge clk); #1;
        check("done_width", 32'(o_done), 32'd0);
        $display("transfer base=0x%02h len=%0d mode=%0d words=%0d", base[7:0], len, mode, accepted);
    endtask

    initial begin
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_base  = '0;
        i_len   = '0;
        i_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a * 16'h0101);

        // Asynchronous reset asserted between edges clears outputs at once.
        @(posedge clk); #3;
        i_rst = 1'b1;
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_raddr", 32'(o_raddr), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        i_rst = 1'b0;
        @(posedge clk); #1;

        run_transfer(8'h10, 3, 0, 1'b0, 0);   // basic
        run_transfer(8'hFE, 4, 0, 1'b0, 0);   // wrap
        run_transfer(8'h40, 16, 1, 1'b0, 0);  // backpressure
        run_transfer(8'h20, 0, 0, 1'b0, 0);   // zero length
        run_transfer(8'h50, 8, 0, 1'b1, 0);   // start while busy is ignored

        // Reset in the middle of a stream drops everything in flight.
        run_transfer(8'h00, 8, 0, 1'b0, 2);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst_quiet", 32'(o_valid), 32'd0);
        end
        i_ready = 1'b0;
        run_transfer(8'h00, 2, 0, 1'b0, 0);

        // Random memory contents, ranges and sink behaviour.
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int t = 0; t < 12; t++) begin
            run_transfer(int'($urandom_range(255)), int'($urandom_range(40, 1)), 2, 1'b0, 0);
        end
        run_transfer(int'($urandom_range(255)), 256, 0, 1'b0, 0);
        run_transfer(int'($urandom_range(255)), 256, 2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
